// File: rtl/multicycle_controller.sv
// multicycle_controller
// ---------------------------------------------------------------------------
// Control FSM for a multicycle RV32I datapath (lw, sw, R-type, I-type ALU,
// beq/bne, jal, lui). One state per clock; every output is decoded from the
// current state and the registered instruction word. In BRANCH, we_pc also
// depends on the combinational ALU zero flag.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   instr[31:0]    instruction register contents
//   zero           ALU zero flag
//   sel_result     00 ALUOut, 01 memory data reg, 10 ALU result
//   we_rf          register-file write
//   sel_ext        000 I, 001 S, 010 B, 011 J, 100 U
//   alu_control    0000 add .. 1001 sltu
//   we_ir          IR / OldPC load
//   we_pc          PC load
//   we_mem         memory write
//   sel_mem_addr   0 PC, 1 ALUOut
//   sel_alu_src_a  00 PC, 01 OldPC, 10 A reg, 11 zero
//   sel_alu_src_b  00 B reg, 01 immediate, 10 constant 4
//   retire         pulse in the last cycle of each completed instruction
//   halted         high while in HALT
// ---------------------------------------------------------------------------
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic [1:0]  sel_result,
    output logic        we_rf,
    output logic [2:0]  sel_ext,
    output logic [3:0]  alu_control,
    output logic        we_ir,
    output logic        we_pc,
    output logic        we_mem,
    output logic        sel_mem_addr,
    output logic [1:0]  sel_alu_src_a,
    output logic [1:0]  sel_alu_src_b,
    output logic        retire,
    output logic        halted
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_LUI      = 4'd8;
    localparam logic [3:0] S_ALUWB    = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_HALT     = 4'd12;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    logic [3:0] state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];

    // Enables before reset gating.
    logic we_rf_int, we_ir_int, we_pc_int, we_mem_int, retire_int, halted_int;

    // funct7[5] selects sub/sra only for register-register ops; for
    // immediates bit 30 is part of the immediate, except on srai.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       is_rtype);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000: op = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = S_FETCH;
        sel_result    = 2'b00;
        sel_ext       = 3'b000;
        alu_control   = ALU_ADD;
        sel_mem_addr  = 1'b0;
        sel_alu_src_a = 2'b00;
        sel_alu_src_b = 2'b00;
        we_rf_int     = 1'b0;
        we_ir_int     = 1'b0;
        we_pc_int     = 1'b0;
        we_mem_int    = 1'b0;
        retire_int    = 1'b0;
        halted_int    = 1'b0;

        case (state_q)
            S_FETCH: begin
                sel_alu_src_b = 2'b10;
                sel_result    = 2'b10;
                we_ir_int     = 1'b1;
                we_pc_int     = 1'b1;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jump target into ALUOut ahead of time.
                sel_alu_src_a = 2'b01;
                sel_alu_src_b = 2'b01;
                sel_ext       = (opcode == OP_JAL) ? 3'b011 : 3'b010;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                sel_alu_src_a = 2'b10;
                sel_alu_src_b = 2'b01;
                sel_ext       = (opcode == OP_STORE) ? 3'b001 : 3'b000;
                state_d       = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                sel_mem_addr = 1'b1;
                state_d      = S_MEMWB;
            end
            S_MEMWB: begin
                sel_result = 2'b01;
                we_rf_int  = 1'b1;
                retire_int = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                sel_mem_addr = 1'b1;
                we_mem_int   = 1'b1;
                retire_int   = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXECR: begin
                sel_alu_src_a = 2'b10;
                alu_control   = alu_decode(funct3, funct7_b5, 1'b1);
                state_d       = S_ALUWB;
            end
            S_EXECI: begin
                sel_alu_src_a = 2'b10;
                sel_alu_src_b = 2'b01;
                alu_control   = alu_decode(funct3, funct7_b5, 1'b0);
                state_d       = S_ALUWB;
            end
            S_LUI: begin
                sel_alu_src_a = 2'b11;
                sel_alu_src_b = 2'b01;
                sel_ext       = 3'b100;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                we_rf_int  = 1'b1;
                retire_int = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // PC <= target held in ALUOut; ALUOut <= OldPC + 4 (link).
                sel_alu_src_a = 2'b01;
                sel_alu_src_b = 2'b10;
                we_pc_int     = 1'b1;
                state_d       = S_ALUWB;
            end
            S_BRANCH: begin
                sel_alu_src_a = 2'b10;
                alu_control   = ALU_SUB;
                case (funct3)
                    3'b000: begin
                        we_pc_int  = zero;
                        retire_int = 1'b1;
                        state_d    = S_FETCH;
                    end
                    3'b001: begin
                        we_pc_int  = ~zero;
                        retire_int = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_HALT: begin
                halted_int = 1'b1;
                state_d    = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset is asynchronous, so enables are gated directly by rst to keep
    // them low the instant reset asserts, independent of the state register.
    assign we_rf  = we_rf_int  & rst;
    assign we_ir  = we_ir_int  & rst;
    assign we_pc  = we_pc_int  & rst;
    assign we_mem = we_mem_int & rst;
    assign retire = retire_int & rst;
    assign halted = halted_int & rst;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = 32'h0000_0013;
    logic        zero = 1'b0;
    logic [1:0]  sel_result;
    logic        we_rf;
    logic [2:0]  sel_ext;
    logic [3:0]  alu_control;
    logic        we_ir;
    logic        we_pc;
    logic        we_mem;
    logic        sel_mem_addr;
    logic [1:0]  sel_alu_src_a;
    logic [1:0]  sel_alu_src_b;
    logic        retire;
    logic        halted;

    multicycle_controller dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .zero          (zero),
        .sel_result    (sel_result),
        .we_rf         (we_rf),
        .sel_ext       (sel_ext),
        .alu_control   (alu_control),
        .we_ir         (we_ir),
        .we_pc         (we_pc),
        .we_mem        (we_mem),
        .sel_mem_addr  (sel_mem_addr),
        .sel_alu_src_a (sel_alu_src_a),
        .sel_alu_src_b (sel_alu_src_b),
        .retire        (retire),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Observed control vector:
    // {sel_result, we_rf, sel_ext, alu, we_ir, we_pc, we_mem, mem_addr, src_a, src_b, retire, halted}
    logic [19:0] obs;
    assign obs = {sel_result, we_rf, sel_ext, alu_control, we_ir, we_pc, we_mem,
                  sel_mem_addr, sel_alu_src_a, sel_alu_src_b, retire, halted};

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [19:0] exp;
        logic        z;
        string       tag;
    } step_t;

    step_t       sb[$];
    logic [31:0] cur_instr = 32'h0000_0013;

    function automatic logic [19:0] v(input logic [1:0] sr, input logic rf,
                                      input logic [2:0] ext, input logic [3:0] alu,
                                      input logic ir, input logic pc, input logic mem,
                                      input logic ma, input logic [1:0] a,
                                      input logic [1:0] b, input logic ret,
                                      input logic hlt);
        return {sr, rf, ext, alu, ir, pc, mem, ma, a, b, ret, hlt};
    endfunction

    task automatic check(input string tag, input logic [19:0] o, input logic [19:0] e);
        n_vec++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
        end
    endtask

    task automatic push(input logic [19:0] e, input logic z, input string tag);
        step_t s;
        s.exp = e;
        s.z   = z;
        s.tag = tag;
        sb.push_back(s);
    endtask

    // Expected per-state vectors.
    function automatic logic [19:0] e_reset();
        return v(2'b10, 0, 3'b000, 4'h0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0);
    endfunction
    function automatic logic [19:0] e_fetch();
        return v(2'b10, 0, 3'b000, 4'h0, 1, 1, 0, 0, 2'b00, 2'b10, 0, 0);
    endfunction
    function automatic logic [19:0] e_decode(input logic j);
        return v(2'b00, 0, j ? 3'b011 : 3'b010, 4'h0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0);
    endfunction
    function automatic logic [19:0] e_aluwb();
        return v(2'b00, 1, 3'b000, 4'h0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    endfunction
    function automatic logic [19:0] e_halt();
        return v(2'b00, 0, 3'b000, 4'h0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    endfunction
    function automatic logic [19:0] e_branch(input logic pc, input logic ret);
        return v(2'b00, 0, 3'b000, 4'b0001, 0, pc, 0, 0, 2'b10, 2'b00, ret, 0);
    endfunction

    // Pops one expected step per clock and compares while the state is stable.
    task automatic drain();
        step_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            instr = cur_instr;
            zero  = s.z;
            #1;
            check(s.tag, obs, s.exp);
        end
    endtask

    task automatic run_r(input logic [31:0] ins, input logic [3:0] alu, input string tag);
        cur_instr = ins;
        push(e_fetch(), 0, {tag, ".fetch"});
        push(e_decode(0), 0, {tag, ".decode"});
        push(v(2'b00, 0, 3'b000, alu, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0), 0, {tag, ".execr"});
        push(e_aluwb(), 0, {tag, ".aluwb"});
        drain();
    endtask

    task automatic run_i(input logic [31:0] ins, input logic [3:0] alu, input string tag);
        cur_instr = ins;
        push(e_fetch(), 0, {tag, ".fetch"});
        push(e_decode(0), 0, {tag, ".decode"});
        push(v(2'b00, 0, 3'b000, alu, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0), 0, {tag, ".execi"});
        push(e_aluwb(), 0, {tag, ".aluwb"});
        drain();
    endtask

    task automatic run_br(input logic [31:0] ins, input logic z, input logic take, input string tag);
        cur_instr = ins;
        push(e_fetch(), z, {tag, ".fetch"});
        push(e_decode(0), z, {tag, ".decode"});
        push(e_branch(take, 1), z, {tag, ".branch"});
        drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.assert", obs, e_reset());
        @(negedge clk);
        #1;
        check("reset.hold", obs, e_reset());
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        // Reset held across several edges.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("reset", obs, e_reset());
        end
        @(posedge clk);
        #2;
        rst = 1'b1;

        run_r(32'h0020_81B3, 4'b0000, "add");
        run_r(32'h4020_81B3, 4'b0001, "sub");
        run_r(32'h0020_C1B3, 4'b0100, "xor");
        run_r(32'h0020_B1B3, 4'b1001, "sltu");
        run_r(32'h4020_D1B3, 4'b1000, "sra");
        run_r(32'h0020_F1B3, 4'b0010, "and");
        run_i(32'h4000_8093, 4'b0000, "addi_b30");
        run_i(32'h4010_D093, 4'b1000, "srai");
        run_i(32'h0060_E093, 4'b0011, "ori");

        // lw: 5 cycles
        cur_instr = 32'h0080_A283;
        push(e_fetch(), 0, "lw.fetch");
        push(e_decode(0), 0, "lw.decode");
        push(v(2'b00, 0, 3'b000, 4'h0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0), 0, "lw.memadr");
        push(v(2'b00, 0, 3'b000, 4'h0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0), 0, "lw.memread");
        push(v(2'b01, 1, 3'b000, 4'h0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0), 0, "lw.memwb");
        drain();

        // sw: 4 cycles, we_mem exactly once, then back to FETCH
        cur_instr = 32'h0050_A223;
        push(e_fetch(), 0, "sw.fetch");
        push(e_decode(0), 0, "sw.decode");
        push(v(2'b00, 0, 3'b001, 4'h0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0), 0, "sw.memadr");
        push(v(2'b00, 0, 3'b000, 4'h0, 0, 0, 1, 1, 2'b00, 2'b00, 1, 0), 0, "sw.memwrite");
        drain();

        run_br(32'h0020_8463, 1'b1, 1'b1, "beq_z1");
        run_br(32'h0020_8463, 1'b0, 1'b0, "beq_z0");
        run_br(32'h0020_9463, 1'b1, 1'b0, "bne_z1");
        run_br(32'h0020_9463, 1'b0, 1'b1, "bne_z0");

        // jal
        cur_instr = 32'h0100_00EF;
        push(e_fetch(), 0, "jal.fetch");
        push(e_decode(1), 0, "jal.decode");
        push(v(2'b00, 0, 3'b000, 4'h0, 0, 1, 0, 0, 2'b01, 2'b10, 0, 0), 0, "jal.jal");
        push(e_aluwb(), 0, "jal.aluwb");
        drain();

        // lui
        cur_instr = 32'h1234_52B7;
        push(e_fetch(), 0, "lui.fetch");
        push(e_decode(0), 0, "lui.decode");
        push(v(2'b00, 0, 3'b100, 4'h0, 0, 0, 0, 0, 2'b11, 2'b01, 0, 0), 0, "lui.lui");
        push(e_aluwb(), 0, "lui.aluwb");
        drain();

        // Reset mid-instruction: abort after DECODE, restart at FETCH.
        cur_instr = 32'h0020_81B3;
        push(e_fetch(), 0, "abort.fetch");
        push(e_decode(0), 0, "abort.decode");
        drain();
        do_reset();
        run_r(32'h0020_81B3, 4'b0000, "post_abort_add");

        // Unsupported branch funct3: no retire, HALT persists.
        cur_instr = 32'h0020_C463;
        push(e_fetch(), 1, "badbr.fetch");
        push(e_decode(0), 1, "badbr.decode");
        push(e_branch(0, 0), 1, "badbr.branch");
        for (int i = 0; i < 4; i++) push(e_halt(), 1, "badbr.halt");
        drain();
        do_reset();

        // Unknown opcode 0x7F -> HALT
        cur_instr = 32'h0000_007F;
        push(e_fetch(), 0, "op7f.fetch");
        push(e_decode(0), 0, "op7f.decode");
        for (int i = 0; i < 3; i++) push(e_halt(), 0, "op7f.halt");
        drain();
        do_reset();

        run_r(32'h0020_81B3, 4'b0000, "final_add");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog: the directed sequence is short; a stall means a broken bench.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I datapath: decodes the registered instruction word and drives every mux select, write enable and ALU operation that the datapath needs, one state per clock. Supports lw, sw, R-type ALU, I-type ALU, beq/bne, jal and lui. It sits beside the datapath and the unified instruction/data memory; the datapath supplies `instr` and `zero`, and this block returns all control signals.

## Interface
Parameters: none.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- instr  in  32  instruction register contents (opcode [6:0], funct3 [14:12], funct7[5] = bit 30)
- zero  in  1  ALU zero flag, combinational from the current ALU operation
- sel_result  out  2  00 ALUOut reg, 01 memory data reg, 10 ALU result
- we_rf  out  1  register-file write
- sel_ext  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- alu_control  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu
- we_ir  out  1  IR and OldPC load
- we_pc  out  1  PC load
- we_mem  out  1  memory write
- sel_mem_addr  out  1  0 PC, 1 ALUOut
- sel_alu_src_a  out  2  00 PC, 01 OldPC, 10 A reg, 11 zero
- sel_alu_src_b  out  2  00 B reg, 01 immediate, 10 constant 4
- retire  out  1  one-cycle pulse in the final state of each instruction
- halted  out  1  high in HALT

## Operation
- Moore FSM; all outputs decode from state, opcode and funct fields. we_pc additionally depends on `zero` in BRANCH.
- Defaults in every state: all enables 0, selects 00, sel_ext 000, alu_control add.
- FETCH: sel_mem_addr=0, we_ir=1, src_a=PC, src_b=4, add, sel_result=10, we_pc=1. Next state: DECODE.
- DECODE: src_a=OldPC, src_b=imm, add. sel_ext=J if opcode 1101111, else B. This precomputes the branch/jump target into ALUOut. Next state by opcode:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - anything else -> HALT
- MEMADR: src_a=A, src_b=imm, add; sel_ext=I for a load, S for a store. Next state: MEMREAD (load) or MEMWRITE (store).
- MEMREAD: sel_mem_addr=1. Next state: MEMWB.
- MEMWB: sel_result=01, we_rf=1, retire. Next state: FETCH.
- MEMWRITE: sel_mem_addr=1, we_mem=1, retire. Next state: FETCH.
- EXECR: src_a=A, src_b=B. ALU op from funct3: 000 add, or sub if funct7[5]; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, or sra if funct7[5]; 110 or; 111 and. Next state: ALUWB.
- EXECI: src_a=A, src_b=imm, sel_ext=I. Same decode, except funct3 000 is always add. Next state: ALUWB.
- LUI: src_a=zero, src_b=imm, sel_ext=U, add. Next state: ALUWB.
- ALUWB: sel_result=00, we_rf=1, retire. Next state: FETCH.
- JAL: src_a=OldPC, src_b=4, add, sel_result=00, we_pc=1. This loads the target from ALUOut into PC while ALUOut captures OldPC+4. Next state: ALUWB (writes the link to rd).
- BRANCH: src_a=A, src_b=B, sub, sel_result=00, retire.
  - funct3 000 (beq): we_pc=zero.
  - funct3 001 (bne): we_pc=~zero.
  - other funct3: next state HALT with we_pc=0 and no retire.
  - Next state otherwise: FETCH.
- HALT: all enables 0, halted=1. The FSM stays in HALT until reset.

## Timing
- While rst=0: state=FETCH, and we_pc, we_ir, we_rf, we_mem, retire and halted are forced to 0. Selects and alu_control take their FETCH values.
- The first FETCH is the first rising edge after rst deasserts.
- Reset mid-instruction aborts the instruction immediately (asynchronous). No write enable may glitch high during reset.
- Cycles per instruction:
  - lw: 5
  - sw, R-type, I-type, lui: 4
  - jal: 4
  - beq/bne: 3
- retire is high exactly once per completed instruction, in its last cycle.
- State register uses one-hot or binary encoding, implementer's choice. Any unreachable encoding returns to FETCH on the next edge.

## Test plan
- Reset: hold rst=0 over several edges with instr=0x00000013 -> all enables 0. After release, edge 1 shows we_ir=1 and we_pc=1 (FETCH), then DECODE.
- `add x3,x1,x2` (0x002081B3) -> FETCH, DECODE, EXECR (alu_control=0000), ALUWB (we_rf=1, sel_result=00, retire=1). Repeat with `sub` (0x402081B3): EXECR alu_control=0001.
- `lw x5,8(x1)` (0x0080A283) -> MEMADR with sel_ext=000, then MEMREAD with sel_mem_addr=1, then MEMWB with sel_result=01 and we_rf=1. Total 5 cycles.
- `sw x5,4(x1)` (0x0050A223) -> MEMADR sel_ext=001, then MEMWRITE with we_mem=1 for exactly one cycle, then FETCH.
- `beq` (0x00208463):
  - zero=1 -> we_pc=1 in BRANCH.
  - zero=0 -> we_pc=0.
  - `bne` with the same operands inverts the result.
  - funct3=100 -> HALT, halted=1, and it persists until rst.
- `jal x1,16` (0x010000EF) -> DECODE sel_ext=011, then JAL with we_pc=1 and src_a=01/src_b=10, then ALUWB with we_rf=1. `lui` (0x123452B7) -> LUI with src_a=11 and sel_ext=100. Opcode 0x7F -> HALT.
